// File: rtl/flash_read_pkg.sv
// Shared types and constants for the single-word flash read master.
package flash_read_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitData,
        StDone,
        StHold
    } state_e;

    localparam logic [3:0]  FLASH_BYTEENABLE    = 4'hF;
    localparam logic [5:0]  FLASH_BURSTCOUNT    = 6'd1;
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/flash_read_ctrl.sv
// Single-word Avalon-MM read master for the on-board flash controller, with a
// bounded timeout that completes a stalled read with an error flag.
module flash_read_ctrl
    import flash_read_pkg::*;
#(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk_50M,
    input  logic              reset_n,
    input  logic              start_read,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] read_data,
    output logic              read_done,
    output logic              error,
    output logic              busy,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    output logic [5:0]        flash_mem_burstcount,
    input  logic              flash_mem_waitrequest,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              flash_mem_readdatavalid
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic              mem_read_q, mem_read_d;

    logic              cnt_expire;
    logic              timeout;
    logic              capture;

    // The counter was cleared on acceptance, so this fires on the
    // TIMEOUT_CYC-th edge spent in ISSUE/WAIT_DATA.
    assign cnt_expire = (cnt_q == CntW'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; timeout wins over a same-edge accept or data beat
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_read) state_d = StIssue;
            end
            StIssue: begin
                if (cnt_expire) begin
                    state_d = StDone;
                    timeout = 1'b1;
                end else if (!flash_mem_waitrequest) begin
                    if (flash_mem_readdatavalid) begin
                        state_d = StDone;
                        capture = 1'b1;
                    end else begin
                        state_d = StWaitData;
                    end
                end
            end
            StWaitData: begin
                if (cnt_expire) begin
                    state_d = StDone;
                    timeout = 1'b1;
                end else if (flash_mem_readdatavalid) begin
                    state_d = StDone;
                    capture = 1'b1;
                end
            end
            StDone: begin
                state_d = StHold;
            end
            StHold: begin
                if (!start_read) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: registered outputs are decoded from the next state
    always_comb begin
        done_d     = (state_d == StDone);
        error_d    = timeout;
        busy_d     = (state_d != StIdle);
        mem_read_d = (state_d == StIssue);
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        data_d = data_q;
        unique case (state_q)
            StIdle: begin
                if (start_read) begin
                    addr_d = address;
                    cnt_d  = '0;
                end
            end
            StIssue, StWaitData: begin
                cnt_d = cnt_q + CntW'(1);
                if (capture) data_d = flash_mem_readdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            mem_read_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            mem_read_q <= mem_read_d;
        end
    end

    assign read_data            = data_q;
    assign read_done            = done_q;
    assign error                = error_q;
    assign busy                 = busy_q;
    assign flash_mem_read       = mem_read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = FLASH_BYTEENABLE;
    assign flash_mem_burstcount = FLASH_BURSTCOUNT;

endmodule

// File: doc/flash_read_ctrl.md
# flash_read_ctrl

Single-word Avalon-MM read master between the Address FSM and the on-board flash controller. It accepts a `start_read` request and a 23-bit word address from the Address FSM and performs one read transaction on the flash controller's Avalon port. It returns the 32-bit word on `read_data` with a one-cycle `read_done` pulse, and aborts a stalled transaction with an error flag after a bounded timeout.

## Interface
- `ADDR_W`, 23: flash word-address width.
- `DATA_W`, 32: data width.
- `TIMEOUT_CYC`, 1023: cycles allowed in ISSUE+WAIT_DATA before abort. Must be ≥ 2.
- `clk_50M` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_read` in 1: request from Address FSM. Level-sampled; may be held high.
- `address` in ADDR_W: word address. Captured when the request is accepted.
- `read_data` out DATA_W: last captured word. Registered; holds its value between reads.
- `read_done` out 1: one-cycle pulse; `read_data` and `error` are valid in that cycle.
- `error` out 1: high only in the `read_done` cycle of a timed-out read.
- `busy` out 1: high in every state except IDLE.
- `flash_mem_read` out 1: Avalon read command.
- `flash_mem_address` out ADDR_W: Avalon address, registered.
- `flash_mem_byteenable` out 4: constant 4'hF.
- `flash_mem_burstcount` out 6: constant 6'd1.
- `flash_mem_waitrequest` in 1.
- `flash_mem_readdata` in DATA_W.
- `flash_mem_readdatavalid` in 1.

## Operation
- States:
  - **IDLE**: `start_read`=1 → capture `address` into `flash_mem_address`, clear the timeout counter, go to ISSUE.
  - **ISSUE**: `flash_mem_read`=1.
    - `waitrequest`=0 and `readdatavalid`=1 at the same edge → capture `readdata`, go to DONE.
    - `waitrequest`=0 otherwise → go to WAIT_DATA.
    - `waitrequest`=1 → stay in ISSUE.
  - **WAIT_DATA**: `flash_mem_read`=0. `readdatavalid`=1 → capture `flash_mem_readdata` into `read_data`, go to DONE.
  - **DONE**: `read_done`=1 for exactly one cycle, then go to HOLD.
  - **HOLD**: wait for `start_read`=0, then go to IDLE. This gives exactly one read per request even when `start_read` is held high across `read_done`.
- Timeout:
  - The counter increments in ISSUE and WAIT_DATA.
  - When it reaches TIMEOUT_CYC, go to DONE with `error`=1. `read_data` is unchanged and `flash_mem_read` drops.
  - Timeout takes priority over an acceptance or `readdatavalid` arriving at the same edge.
- `readdatavalid` outside ISSUE/WAIT_DATA (e.g. late data after a timeout) is ignored.
- Changes on `address` while busy are ignored.
- `address` wraps naturally within ADDR_W; there is no incrementing inside this block.

## Timing
- Reset values: state IDLE; `read_data`=0, `read_done`=0, `error`=0, `busy`=0, `flash_mem_read`=0, `flash_mem_address`=0. Counter is 0.
- Constant outputs (`byteenable`=4'hF, `burstcount`=1) are valid during reset.
- All outputs are registered; no combinational path from input to output.
- `start_read` sampled high at edge k:
  - `flash_mem_read` is high after edge k.
  - If `waitrequest`=0 at edge k+1 and `readdatavalid` at edge k+2, then `read_done` is high for the cycle after edge k+2.
  - Minimum latency (data at the acceptance edge k+1): `read_done` after edge k+1.
- `flash_mem_address` is stable from edge k until the next accepted request.
- `reset_n` asserted mid-transaction: immediate return to reset values. No `read_done` is produced for the aborted read.
- Next request: earliest two cycles after `read_done` (through HOLD with `start_read`=0, then IDLE).

## Structure
- `flash_read_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT_DATA, DONE, HOLD);
  - the constants `FLASH_BYTEENABLE`=4'hF and `FLASH_BURSTCOUNT`=6'd1;
  - the default `TIMEOUT_CYC`.
- Single module, no sub-modules. The timeout counter is inline, width $clog2(TIMEOUT_CYC+1).

## Test plan
- **Basic read:** `address`=23'h000010, `waitrequest`=0, `readdatavalid` one cycle after acceptance with `readdata`=32'hDEADBEEF → `flash_mem_address`=23'h000010, one `read_done` pulse, `read_data`=32'hDEADBEEF, `error`=0.
- **Wait states:** `waitrequest` held high 5 cycles, then data 3 cycles later → `flash_mem_read` high for exactly 6 cycles, one `read_done`.
- **Held request:** `start_read` held high through `read_done` → no second `flash_mem_read` until `start_read` goes low then high again. Second address 23'h7FFFFF is issued correctly.
- **Timeout:** TIMEOUT_CYC=8, `waitrequest` stuck high → `read_done`=1 with `error`=1 after 8 cycles in ISSUE, `read_data` unchanged. A later `readdatavalid` with 32'h12345678 is ignored.
- **Reset mid-read:** `reset_n` pulled low in WAIT_DATA → all outputs return to reset values asynchronously; no `read_done`; a fresh request afterwards completes normally.
- **Same-edge data:** acceptance and `readdatavalid` at the same edge with 32'hCAFEF00D → DONE directly, `read_data`=32'hCAFEF00D.
